// File: rtl/lc3_dmem_ctrl.sv
// rtl/lc3_dmem_ctrl.sv - LC3 data-memory controller with wait states and preload port
// Optional out-of-range detection enabled by defining LC3_DMEM_RANGE_CHECK_EN.
module lc3_dmem_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int MEM_DEPTH   = 256,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_req,
    output logic        dmem_ack,
    input  logic [15:0] dmem_addr,
    input  logic [15:0] dmem_din,
    input  logic        dmem_rd,
    output logic [15:0] memout,
    output logic        memout_valid,
    output logic        wr_done,
    output logic        busy,
`ifdef LC3_DMEM_RANGE_CHECK_EN
    output logic        addr_err,
`endif
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic        rd_q, rd_d;
    logic [15:0] memout_q, memout_d;

    logic [15:0] mem [MEM_DEPTH];

    logic        accept;
    logic        commit;
    logic [15:0] c_addr;
    logic [15:0] c_din;
    logic        c_rd;
    logic        c_oor;
    logic        ld_oor;
    logic        q_oor;
    logic        mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [15:0] mem_wdata;

    assign accept = (state_q == S_IDLE) && dmem_req && !ld_en;

    // With zero wait states the acceptance edge is also the commit edge, so the
    // request is taken straight from the ports rather than the latched copy.
    assign c_addr = (state_q == S_IDLE) ? dmem_addr : addr_q;
    assign c_din  = (state_q == S_IDLE) ? dmem_din  : din_q;
    assign c_rd   = (state_q == S_IDLE) ? dmem_rd   : rd_q;
    assign commit = (accept && (WAIT_STATES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));

`ifdef LC3_DMEM_RANGE_CHECK_EN
    assign c_oor  = ({1'b0, c_addr}  >= 17'(MEM_DEPTH));
    assign ld_oor = ({1'b0, ld_addr} >= 17'(MEM_DEPTH));
    assign q_oor  = ({1'b0, addr_q}  >= 17'(MEM_DEPTH));
`else
    assign c_oor  = 1'b0;
    assign ld_oor = 1'b0;
    assign q_oor  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            din_q    <= 16'h0000;
            rd_q     <= 1'b0;
            memout_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_q     <= rd_d;
            memout_q <= memout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = dmem_addr;
                    din_d  = dmem_din;
                    rd_d   = dmem_rd;
                    if (WAIT_STATES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        memout_d = memout_q;
        if (commit && c_rd) begin
            memout_d = c_oor ? 16'h0000 : mem[c_addr[IDX_W-1:0]];
        end
    end

    // Preload and commit writes never coincide: acceptance in IDLE requires !ld_en.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = c_addr[IDX_W-1:0];
        mem_wdata = c_din;
        if (commit && !c_rd && !c_oor) begin
            mem_we = 1'b1;
        end else if ((state_q == S_IDLE) && ld_en && !ld_oor) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr[IDX_W-1:0];
            mem_wdata = ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        dmem_ack     = (state_q == S_IDLE) && !ld_en;
        busy         = (state_q != S_IDLE);
        memout_valid = (state_q == S_DONE) && rd_q;
        wr_done      = (state_q == S_DONE) && !rd_q;
        memout       = memout_q;
`ifdef LC3_DMEM_RANGE_CHECK_EN
        addr_err     = (state_q == S_DONE) && q_oor;
`endif
    end

endmodule

// File: tb/tb_lc3_dmem_ctrl.sv
// tb/tb_lc3_dmem_ctrl.sv - self-checking bench for lc3_dmem_ctrl
module tb_lc3_dmem_ctrl;

    localparam int WS = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_req = 1'b0, a_ack, a_rd = 1'b0, a_valid, a_wr_done, a_busy, a_ld_en = 1'b0;
    logic [15:0] a_addr = '0, a_din = '0, a_memout, a_ld_addr = '0, a_ld_data = '0;
`ifdef LC3_DMEM_RANGE_CHECK_EN
    logic        a_addr_err, b_addr_err;
`endif

    logic        b_req = 1'b0, b_ack, b_rd = 1'b0, b_valid, b_wr_done, b_busy, b_ld_en = 1'b0;
    logic [15:0] b_addr = '0, b_din = '0, b_memout, b_ld_addr = '0, b_ld_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    lc3_dmem_ctrl #(.WAIT_STATES(WS), .MEM_DEPTH(256)) dut_a (
        .clock(clock), .reset(rst_n),
        .dmem_req(a_req), .dmem_ack(a_ack), .dmem_addr(a_addr), .dmem_din(a_din), .dmem_rd(a_rd),
        .memout(a_memout), .memout_valid(a_valid), .wr_done(a_wr_done), .busy(a_busy),
`ifdef LC3_DMEM_RANGE_CHECK_EN
        .addr_err(a_addr_err),
`endif
        .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
    );

    lc3_dmem_ctrl #(.WAIT_STATES(0), .MEM_DEPTH(256)) dut_b (
        .clock(clock), .reset(rst_n),
        .dmem_req(b_req), .dmem_ack(b_ack), .dmem_addr(b_addr), .dmem_din(b_din), .dmem_rd(b_rd),
        .memout(b_memout), .memout_valid(b_valid), .wr_done(b_wr_done), .busy(b_busy),
`ifdef LC3_DMEM_RANGE_CHECK_EN
        .addr_err(b_addr_err),
`endif
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [15:0] addr, input logic [15:0] data);
        a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = data;
        @(negedge clock);
        chk("ack_low_on_ld", a_ack, 16'd0);
        next_cycle();
        a_ld_en = 1'b0;
    endtask

    task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                          input logic [15:0] exp);
        a_req = 1'b1; a_rd = rd; a_addr = addr; a_din = din;
        @(negedge clock);
        chk("ack_cycle0", a_ack, 16'd1);
        next_cycle();
        a_req = 1'b0;
        for (int c = 1; c <= WS + 1; c++) begin
            @(negedge clock);
            chk("busy_active", a_busy, 16'd1);
            if (c == WS + 1) begin
                chk("memout_valid", a_valid, 16'(rd));
                chk("wr_done", a_wr_done, 16'(!rd));
                chk("memout", a_memout, exp);
`ifdef LC3_DMEM_RANGE_CHECK_EN
                chk("addr_err", a_addr_err, 16'(addr >= 16'd256));
`endif
            end else begin
                chk("pulse_early", {a_valid, a_wr_done}, 16'd0);
            end
            next_cycle();
        end
        @(negedge clock);
        chk("ack_return", a_ack, 16'd1);
        chk("busy_clear", a_busy, 16'd0);
        chk("pulse_gone", {a_valid, a_wr_done}, 16'd0);
        next_cycle();
    endtask

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    localparam int OP_LD = 0;
    localparam int OP_WR = 1;
    localparam int OP_RD = 2;

    vec_t tbl[9];

    initial begin
        int pulses;
        logic [15:0] seen;

        tbl[0] = '{OP_LD, 16'h0010, 16'h1234, 16'h0000};
        tbl[1] = '{OP_RD, 16'h0010, 16'h0000, 16'h1234};
        tbl[2] = '{OP_WR, 16'h00AB, 16'hBEEF, 16'h1234};
        tbl[3] = '{OP_RD, 16'h00AB, 16'h0000, 16'hBEEF};
`ifdef LC3_DMEM_RANGE_CHECK_EN
        tbl[4] = '{OP_RD, 16'h0110, 16'h0000, 16'h0000};
`else
        tbl[4] = '{OP_RD, 16'h0110, 16'h0000, 16'h1234};
`endif
        tbl[5] = '{OP_LD, 16'h00FF, 16'h0F0F, 16'h0000};
        tbl[6] = '{OP_RD, 16'h00FF, 16'h0000, 16'h0F0F};
        tbl[7] = '{OP_WR, 16'h0000, 16'hCAFE, 16'h0F0F};
        tbl[8] = '{OP_RD, 16'h0000, 16'h0000, 16'hCAFE};

        #2;
        chk("rst_memout", a_memout, 16'h0000);
        chk("rst_ack", a_ack, 16'd1);
        chk("rst_busy", a_busy, 16'd0);
        chk("rst_pulses", {a_valid, a_wr_done}, 16'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            case (tbl[i].op)
                OP_LD:   preload(tbl[i].addr, tbl[i].data);
                OP_WR:   access(1'b0, tbl[i].addr, tbl[i].data, tbl[i].exp);
                default: access(1'b1, tbl[i].addr, tbl[i].data, tbl[i].exp);
            endcase
        end

        // Reset during WAIT aborts a pending write and clears outputs immediately.
        preload(16'h0020, 16'h5555);
        a_req = 1'b1; a_rd = 1'b0; a_addr = 16'h0020; a_din = 16'hAAAA;
        next_cycle();
        a_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_memout", a_memout, 16'h0000);
        chk("midrst_busy", a_busy, 16'd0);
        chk("midrst_ack", a_ack, 16'd1);
        chk("midrst_pulses", {a_valid, a_wr_done}, 16'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (a_wr_done) pulses++;
            next_cycle();
        end
        chk("midrst_no_wr_done", 16'(pulses), 16'd0);
        access(1'b1, 16'h0020, 16'h0000, 16'h5555);

        // Preload wins over a simultaneous request; request then accepted once.
        a_ld_en = 1'b1; a_ld_addr = 16'h0030; a_ld_data = 16'h7777;
        a_req = 1'b1; a_rd = 1'b1; a_addr = 16'h0030;
        @(negedge clock);
        chk("ld_prio_ack", a_ack, 16'd0);
        next_cycle();
        a_ld_en = 1'b0;
        @(negedge clock);
        chk("ld_then_ack", a_ack, 16'd1);
        pulses = 0;
        seen = 16'h0000;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == WS + 2) a_req = 1'b0;
            @(negedge clock);
            if (a_valid) begin
                pulses++;
                seen = a_memout;
            end
        end
        chk("single_pulse", 16'(pulses), 16'd1);
        chk("ld_then_read", seen, 16'h7777);
        next_cycle();

        // Zero-wait-state instance: pulse in cycle 1, ack back in cycle 2.
        b_req = 1'b1; b_rd = 1'b0; b_addr = 16'h00AB; b_din = 16'hBEEF;
        @(negedge clock);
        chk("b_ack_c0", b_ack, 16'd1);
        next_cycle();
        b_req = 1'b0;
        @(negedge clock);
        chk("b_wr_done_c1", b_wr_done, 16'd1);
        chk("b_busy_c1", b_busy, 16'd1);
        chk("b_memout_keep", b_memout, 16'h0000);
        next_cycle();
        b_req = 1'b1; b_rd = 1'b1;
        @(negedge clock);
        chk("b_ack_c2", b_ack, 16'd1);
        next_cycle();
        b_req = 1'b0;
        @(negedge clock);
        chk("b_valid_c1", b_valid, 16'd1);
        chk("b_memout", b_memout, 16'hBEEF);
        next_cycle();
        @(negedge clock);
        chk("b_idle", b_busy, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
